instr_fetch_unit: RTL and testbench

//  Initiator side of the program-memory address interface: owns the PC, drives ADDR_Prog

---
 rtl/risc_mem_map_pkg.sv | 21 ++
 rtl/prog_window_check.sv | 16 +
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_mem_map_pkg.sv
// Program memory map shared by the fetch unit and the program-address decoder:
// window bounds, address/word types and the fetch state encoding.
package risc_mem_map_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    // Program window, inclusive on both ends; PROG_BASE doubles as the reset vector.
    localparam addr_t PROG_BASE  = 32'h0000_0410;
    localparam addr_t PROG_LIMIT = 32'h0000_080F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/prog_window_check.sv
// Combinational test of whether an address lies inside the program window.
// Shared between the fetch unit and the decoder side of the address bus.
module prog_window_check
    import risc_mem_map_pkg::*;
#(
    parameter addr_t BASE  = risc_mem_map_pkg::PROG_BASE,
    parameter addr_t LIMIT = risc_mem_map_pkg::PROG_LIMIT
) (
    input  addr_t addr,
    output logic  in_window
);

    // Inclusive bounds on both sides, unsigned compare.
    assign in_window = (addr >= BASE) && (addr <= LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one program-memory read at a
// time, presents the returned word to decode with a valid/ready handshake,
// accepts branch redirects and raises a sticky fault on an out-of-window PC
// or a memory response timeout.
module instr_fetch_unit #(
    parameter logic [31:0] PROG_BASE  = risc_mem_map_pkg::PROG_BASE,
    parameter logic [31:0] PROG_LIMIT = risc_mem_map_pkg::PROG_LIMIT,
    parameter int unsigned STEP       = 1,
    parameter int unsigned TIMEOUT    = 15,
    parameter int          TO_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ADDR_Prog,
    output logic        fetch_req,
    input  logic [31:0] inst_rdata,
    input  logic        inst_rvalid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        fault
);

    import risc_mem_map_pkg::*;

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    addr_t           pc;
    addr_t           pc_nxt;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nxt;
    logic [TO_W-1:0] cnt_inc;
    logic            timeout_hit;
    word_t           out_nxt;
    addr_t           ipc_nxt;
    logic            valid_nxt;
    logic            fault_nxt;
    logic            req_nxt;
    logic            pc_in_window;
    logic            pc_nxt_in_window;

    // The address bus is the PC register itself, so it is glitch-free.
    assign ADDR_Prog = pc;

    assign cnt_inc     = cnt + {{(TO_W-1){1'b0}}, 1'b1};
    assign timeout_hit = (cnt_inc == TO_W'(TIMEOUT));

    // Current PC decides REQ -> WAIT versus REQ -> FAULT.
    prog_window_check #(
        .BASE  (PROG_BASE),
        .LIMIT (PROG_LIMIT)
    ) u_win_cur (
        .addr      (pc),
        .in_window (pc_in_window)
    );

    // Next PC decides whether the strobe goes out on entry to REQ, which keeps
    // fetch_req a registered output aligned with the REQ cycle.
    prog_window_check #(
        .BASE  (PROG_BASE),
        .LIMIT (PROG_LIMIT)
    ) u_win_nxt (
        .addr      (pc_nxt),
        .in_window (pc_nxt_in_window)
    );

    // Next-state and next-output decode; redirect overrides every state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        out_nxt   = inst_out;
        ipc_nxt   = inst_pc;
        valid_nxt = inst_valid;
        fault_nxt = fault;

        if (redirect) begin
            // A HOLD handshake completing this cycle is simply not repeated;
            // an in-flight WAIT response must be swallowed in DRAIN unless it
            // arrives right now, in which case it is dropped here.
            pc_nxt    = redirect_addr;
            valid_nxt = 1'b0;
            fault_nxt = 1'b0;
            cnt_nxt   = '0;
            state_nxt = (state == ST_WAIT && !inst_rvalid) ? ST_DRAIN : ST_REQ;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_REQ;
                end
                ST_REQ: begin
                    if (pc_in_window) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_WAIT;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_FAULT;
                    end
                end
                ST_WAIT: begin
                    // A response in the final allowed cycle still counts.
                    if (inst_rvalid) begin
                        out_nxt   = inst_rdata;
                        ipc_nxt   = pc;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc + STEP;
                        state_nxt = ST_HOLD;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (timeout_hit) begin
                            fault_nxt = 1'b1;
                            state_nxt = ST_FAULT;
                        end
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        valid_nxt = 1'b0;
                        state_nxt = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Stale response or its timeout both end the drain quietly.
                    if (inst_rvalid) begin
                        state_nxt = ST_REQ;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (timeout_hit) begin
                            state_nxt = ST_REQ;
                        end
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        req_nxt = (state_nxt == ST_REQ) && pc_nxt_in_window;
    end

    // State, PC, counter and all outputs registered; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= PROG_BASE;
            cnt        <= '0;
            fetch_req  <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            cnt        <= cnt_nxt;
            fetch_req  <= req_nxt;
            inst_out   <= out_nxt;
            inst_pc    <= ipc_nxt;
            inst_valid <= valid_nxt;
            fault      <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural memory responder and
// a reference model of the fetch sequencing, directed scenarios followed by a
// randomized run.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ADDR_Prog;
    logic        fetch_req;
    logic [31:0] inst_rdata = '0;
    logic        inst_rvalid = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        fault;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ADDR_Prog     (ADDR_Prog),
        .fetch_req     (fetch_req),
        .inst_rdata    (inst_rdata),
        .inst_rvalid   (inst_rvalid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fault         (fault)
    );

    localparam logic [31:0] BASE  = 32'h410;
    localparam logic [31:0] LIMIT = 32'h80F;
    localparam int          TMO   = 15;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus controls
    int          mem_lat     = 1;
    logic        rand_lat    = 1'b0;
    int          ready_pct   = 100;
    int          redir_pct   = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_addr  = '0;

    // memory responder
    logic        pend = 1'b0;
    int          due  = 0;
    logic [31:0] resp_addr = '0;

    // reference model: phase of the fetch sequence plus visible outputs
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3, P_DRAIN = 4, P_FAULT = 5;
    int          m_ph;
    int          m_age;
    logic [31:0] m_pc, m_out, m_ipc;
    logic        m_req, m_valid, m_fault;

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= LIMIT);
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_age = 0; m_pc = BASE; m_out = '0; m_ipc = '0;
        m_req = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic rdr, input logic [31:0] ra);
        if (!rst) begin
            model_reset();
            return;
        end
        if (rdr) begin
            m_ph    = (m_ph == P_WAIT && !rv) ? P_DRAIN : P_REQ;
            m_pc    = ra;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_age   = 0;
        end else begin
            case (m_ph)
                P_IDLE: m_ph = P_REQ;
                P_REQ: begin
                    if (in_win(m_pc)) begin m_ph = P_WAIT; m_age = 0; end
                    else begin m_fault = 1'b1; m_ph = P_FAULT; end
                end
                P_WAIT: begin
                    if (rv) begin
                        m_out = rd; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 1; m_ph = P_HOLD;
                    end else begin
                        m_age++;
                        if (m_age == TMO) begin m_fault = 1'b1; m_ph = P_FAULT; end
                    end
                end
                P_HOLD: if (rdy) begin m_valid = 1'b0; m_ph = P_REQ; end
                P_DRAIN: begin
                    if (rv) m_ph = P_REQ;
                    else begin
                        m_age++;
                        if (m_age == TMO) m_ph = P_REQ;
                    end
                end
                default: ;
            endcase
        end
        m_req = (m_ph == P_REQ) && in_win(m_pc);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("ADDR_Prog", ADDR_Prog, m_pc);
        chk("fetch_req", {31'd0, fetch_req}, {31'd0, m_req});
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("inst_out", inst_out, m_out);
        chk("inst_pc", inst_pc, m_ipc);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(9);
        if (r == 0) return 32'h40F;
        if (r == 1) return LIMIT - $urandom_range(2);
        if (r == 2) return 32'h810;
        return BASE + $urandom_range(32'h3FF);
    endfunction

    // One clock: choose inputs for the current cycle, advance, check outputs.
    task automatic cycle();
        logic        rv, rdy, rdr;
        logic [31:0] rd, ra;
        int          lat;
        rv = 1'b0;
        rd = $urandom;
        if (pend) begin
            due--;
            if (due <= 0) begin rv = 1'b1; pend = 1'b0; rd = memword(resp_addr); end
        end
        if (fetch_req === 1'b1) begin
            lat = mem_lat;
            if (rand_lat) begin
                int r;
                r = $urandom_range(99);
                if (r < 85) lat = 1 + $urandom_range(3);
                else if (r < 95) lat = 14 + $urandom_range(2);
                else lat = 0;
            end
            if (lat > 0) begin pend = 1'b1; due = lat; resp_addr = ADDR_Prog; end
        end
        rdy = ($urandom_range(99) < ready_pct);
        rdr = 1'b0;
        ra  = $urandom;
        if (force_redir) begin
            rdr = 1'b1; ra = force_addr; force_redir = 1'b0;
        end else if (fetch_req !== 1'b1 && $urandom_range(99) < redir_pct) begin
            rdr = 1'b1; ra = pick_addr();
        end
        inst_rvalid   = rv;
        inst_rdata    = rd;
        inst_ready    = rdy;
        redirect      = rdr;
        redirect_addr = ra;
        @(posedge clk);
        model_step(rst_n, rv, rd, rdy, rdr, ra);
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d got=no-event expected=event", nm, cyc);
    endtask

    task automatic wait_strobe(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (fetch_req === 1'b1) return;
            cycle();
        end
        if (fetch_req !== 1'b1) bound_fail("wait_strobe");
    endtask

    task automatic redirect_to(input logic [31:0] a);
        for (int i = 0; i < 20 && fetch_req === 1'b1; i++) cycle();
        force_redir = 1'b1;
        force_addr  = a;
        cycle();
    endtask

    initial begin
        int          s_cyc [3];
        logic [31:0] s_addr[3];
        int          s;
        logic        seen;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_addr", ADDR_Prog, 32'h410);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        #2 rst_n = 1'b1;

        // 1: sequential fetch, latency 1, always ready
        mem_lat = 1; ready_pct = 100;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(10);
            s_cyc[k]  = cyc;
            s_addr[k] = ADDR_Prog;
            cycle();
        end
        chk("seq_addr0", s_addr[0], 32'h410);
        chk("seq_addr1", s_addr[1], 32'h411);
        chk("seq_addr2", s_addr[2], 32'h412);
        chk("seq_gap01", s_cyc[1] - s_cyc[0], 32'd3);
        chk("seq_gap12", s_cyc[2] - s_cyc[1], 32'd3);

        // 2: decode stalls five cycles in HOLD
        ready_pct = 0;
        for (int i = 0; i < 10 && inst_valid !== 1'b1; i++) cycle();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin cycle(); seen |= fetch_req; end
        chk("hold_pc", inst_pc, 32'h412);
        chk("hold_out", inst_out, memword(32'h412));
        chk("hold_noreq", {31'd0, seen}, 32'd0);
        ready_pct = 100;
        wait_strobe(10);
        chk("after_hold_addr", ADDR_Prog, 32'h413);

        // 3: last window address, then fault, then recovery by redirect
        redirect_to(32'h80F);
        for (int i = 0; i < 20 && fault !== 1'b1; i++) cycle();
        chk("edge_fault", {31'd0, fault}, 32'd1);
        chk("edge_addr", ADDR_Prog, 32'h810);
        redirect_to(32'h500);
        chk("recover_fault", {31'd0, fault}, 32'd0);
        chk("recover_addr", ADDR_Prog, 32'h500);
        chk("recover_req", {31'd0, fetch_req}, 32'd1);

        // 4: timeout boundary
        mem_lat = 0;
        wait_strobe(10);
        s = cyc;
        for (int i = 0; i < 40 && fault !== 1'b1; i++) cycle();
        chk("timeout_cycles", cyc - s, 32'd16);
        mem_lat = 15;
        redirect_to(32'h410);
        wait_strobe(10);
        seen = 1'b0;
        for (int i = 0; i < 17; i++) begin cycle(); seen |= inst_valid; end
        chk("late15_nofault", {31'd0, fault}, 32'd0);
        chk("late15_valid", {31'd0, seen}, 32'd1);

        // 5: redirect during WAIT, stale response two cycles later
        mem_lat = 3;
        wait_strobe(10);
        s = cyc;
        cycle();
        redirect_to(32'h600);
        wait_strobe(20);
        chk("drain_addr", ADDR_Prog, 32'h600);
        chk("drain_gap", cyc - s, 32'd4);

        // 6: asynchronous reset mid-WAIT, response lands in IDLE
        mem_lat = 2;
        wait_strobe(10);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_addr", ADDR_Prog, 32'h410);
        cycle();
        #2 rst_n = 1'b1;
        cycle();
        wait_strobe(10);
        chk("restart_addr", ADDR_Prog, 32'h410);

        // Randomized traffic
        rand_lat = 1'b1; ready_pct = 70; redir_pct = 4;
        for (int i = 0; i < 3000; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
